// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter.
// Two writeback requesters (req0 = EX result, req1 = MEM load result) share
// the single register-file write port. A round-robin arbiter picks one
// requester per cycle. The winner is captured in a registered output stage
// that drives A3/WD/RFWr directly. A per-register scoreboard tracks
// outstanding producers, and the decode stage sees a read-hazard stall.
module rf_wb_arbiter #(
  parameter int AW   = 5,
  parameter int DW   = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  // issue side: a new producer of issue_rd is in flight
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  // decode-stage source operands
  input  logic [AW-1:0]   rs_addr,
  input  logic [AW-1:0]   rt_addr,
  output logic            hazard_stall,
  // EX writeback requester
  input  logic            req0_valid,
  input  logic [AW-1:0]   req0_addr,
  input  logic [DW-1:0]   req0_data,
  output logic            req0_ready,
  // MEM writeback requester
  input  logic            req1_valid,
  input  logic [AW-1:0]   req1_addr,
  input  logic [DW-1:0]   req1_data,
  output logic            req1_ready,
  // register file write port
  output logic [AW-1:0]   rf_a3,
  output logic [DW-1:0]   rf_wd,
  output logic            rf_wr,
  // scoreboard contents
  output logic [NREG-1:0] busy_vec
);

  // last_grant_reg = 1 means req1 won the most recent arbitration
  logic            last_grant_reg;
  logic            grant0;
  logic            grant1;
  logic            accept;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;

  logic [AW-1:0]   rf_a3_reg;
  logic [DW-1:0]   rf_wd_reg;
  logic            rf_wr_reg;

  logic [NREG-1:0] busy_reg;
  logic [NREG-1:0] busy_next;

  // Round-robin grant: a lone requester wins, a tie goes to the one not served last
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (req0_valid && req1_valid) begin
      if (last_grant_reg) grant0 = 1'b1;
      else                grant1 = 1'b1;
    end else if (req0_valid) begin
      grant0 = 1'b1;
    end else if (req1_valid) begin
      grant1 = 1'b1;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign accept     = grant0 | grant1;

  // Winner's payload; only meaningful when accept is high
  always_comb begin
    win_addr = req0_addr;
    win_data = req0_data;
    if (grant1) begin
      win_addr = req1_addr;
      win_data = req1_data;
    end
  end

  // Output stage: capture the accepted write; the write strobe is a one-cycle pulse.
  // A3/WD hold their last value when idle so the register file sees a quiet bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_a3_reg      <= '0;
      rf_wd_reg      <= '0;
      rf_wr_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      if (accept) begin
        rf_a3_reg      <= win_addr;
        rf_wd_reg      <= win_data;
        rf_wr_reg      <= (win_addr != '0);
        last_grant_reg <= grant1;
      end else begin
        rf_wr_reg      <= 1'b0;
      end
    end
  end

  assign rf_a3 = rf_a3_reg;
  assign rf_wd = rf_wd_reg;
  assign rf_wr = rf_wr_reg;

  // Per-register next state: a new issue beats a commit of the same register,
  // because the issue names a producer that has not written yet. Register 0
  // never holds a pending write.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_busy
      if (gi == 0) begin : g_zero
        assign busy_next[gi] = 1'b0;
      end else begin : g_reg
        logic set_bit;
        logic clr_bit;
        assign set_bit = issue_valid && (issue_rd == AW'(gi));
        assign clr_bit = rf_wr_reg   && (rf_a3_reg == AW'(gi));
        assign busy_next[gi] = set_bit | (busy_reg[gi] & ~clr_bit);
      end
    end
  endgenerate

  // Scoreboard register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_reg <= '0;
    else        busy_reg <= busy_next;
  end

  assign busy_vec = busy_reg;

  // No bypass: a source stays stalled until the cycle after its commit edge
  assign hazard_stall = ((rs_addr != '0) && busy_reg[rs_addr]) ||
                        ((rt_addr != '0) && busy_reg[rt_addr]);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Testbench for rf_wb_arbiter: directed scenarios followed by randomized
// traffic, all checked against a transaction-level reference model.
module tb_rf_wb_arbiter;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            issue_valid = 1'b0;
  logic [AW-1:0]   issue_rd = '0;
  logic [AW-1:0]   rs_addr = '0;
  logic [AW-1:0]   rt_addr = '0;
  logic            hazard_stall;
  logic            req0_valid = 1'b0;
  logic [AW-1:0]   req0_addr = '0;
  logic [DW-1:0]   req0_data = '0;
  logic            req0_ready;
  logic            req1_valid = 1'b0;
  logic [AW-1:0]   req1_addr = '0;
  logic [DW-1:0]   req1_data = '0;
  logic            req1_ready;
  logic [AW-1:0]   rf_a3;
  logic [DW-1:0]   rf_wd;
  logic            rf_wr;
  logic [NREG-1:0] busy_vec;

  rf_wb_arbiter #(.AW(AW), .DW(DW), .NREG(NREG)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .hazard_stall(hazard_stall),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .rf_a3(rf_a3), .rf_wd(rf_wd), .rf_wr(rf_wr), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  // Reference model: set of outstanding registers, who was served last,
  // and the write the register file is expected to see next cycle.
  bit          m_busy[NREG];
  int          m_last;
  bit          m_wr;
  int          m_a3;
  logic [31:0] m_wd;
  int          acc;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_vec();
    logic [31:0] v;
    v = '0;
    for (int r = 1; r < NREG; r++) v[r] = m_busy[r];
    return v;
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) m_busy[r] = 1'b0;
    m_last = 1;
    m_wr   = 1'b0;
    m_a3   = 0;
    m_wd   = '0;
  endtask

  // One clock cycle: inputs are already driven (after a negedge); check all
  // outputs against the model, advance the model across the posedge.
  task automatic step();
    int          g;
    int          ga;
    logic [31:0] gd;
    bit          stall_e;
    #1;
    if (req0_valid && req1_valid) g = (m_last == 1) ? 0 : 1;
    else if (req0_valid)          g = 0;
    else if (req1_valid)          g = 1;
    else                          g = -1;
    stall_e = (rs_addr != 0 && m_busy[rs_addr]) || (rt_addr != 0 && m_busy[rt_addr]);
    check("req0_ready", req0_ready, g == 0);
    check("req1_ready", req1_ready, g == 1);
    check("hazard_stall", hazard_stall, stall_e);
    check("rf_wr", rf_wr, m_wr);
    check("rf_a3", rf_a3, m_a3);
    check("rf_wd", rf_wd, m_wd);
    check("busy_vec", busy_vec, model_vec());
    ga = (g == 1) ? int'(req1_addr) : int'(req0_addr);
    gd = (g == 1) ? req1_data : req0_data;
    // commit of the previous write clears, then a new issue sets (issue wins)
    if (m_wr) m_busy[m_a3] = 1'b0;
    if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    if (g >= 0) begin
      m_wr   = (ga != 0);
      m_a3   = ga;
      m_wd   = gd;
      m_last = g;
      $display("[TB] t=%0t grant=req%0d addr=%0d data=0x%08h stall=%0b", $time, g, ga, gd, hazard_stall);
    end else begin
      m_wr = 1'b0;
    end
    acc = g;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    issue_valid = 1'b0; issue_rd = '0; rs_addr = '0; rt_addr = '0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    clear_inputs();
    #2;
    // reset state
    check("rst_rf_wr", rf_wr, 0);
    check("rst_rf_a3", rf_a3, 0);
    check("rst_rf_wd", rf_wd, 0);
    check("rst_busy", busy_vec, 0);
    check("rst_stall", hazard_stall, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // single req0 write to r5
    req0_valid = 1'b1; req0_addr = 5; req0_data = 32'h1234;
    step();
    check("single_acc", acc, 0);
    req0_valid = 1'b0;
    #1;
    check("single_wr", rf_wr, 1);
    check("single_a3", rf_a3, 5);
    check("single_wd", rf_wd, 32'h0000_1234);
    step();
    #1;
    check("single_wr_drop", rf_wr, 0);
    step();

    // tie, round-robin from reset
    apply_reset();
    req0_valid = 1'b1; req0_addr = 3; req0_data = 32'hA;
    req1_valid = 1'b1; req1_addr = 4; req1_data = 32'hB;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_grant", acc, i % 2);
      #1;
      check("rr_a3", rf_a3, (i % 2 == 0) ? 3 : 4);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    // scoreboard and stall on r7
    issue_valid = 1'b1; issue_rd = 7;
    step();
    issue_valid = 1'b0; rs_addr = 7;
    #1;
    check("sb_stall_set", hazard_stall, 1);
    req1_valid = 1'b1; req1_addr = 7; req1_data = 32'hCAFE_0007;
    step();
    req1_valid = 1'b0;
    #1;
    check("sb_wr_cycle", rf_wr, 1);
    check("sb_stall_commit", hazard_stall, 1);
    step();
    #1;
    check("sb_stall_drop", hazard_stall, 0);
    check("sb_busy7", busy_vec[7], 0);
    step();

    // set/clear collision on r9
    rs_addr = 9;
    issue_valid = 1'b1; issue_rd = 9;
    step();
    issue_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 9; req0_data = 32'h9999;
    step();
    req0_valid = 1'b0;
    issue_valid = 1'b1; issue_rd = 9;
    step();
    issue_valid = 1'b0;
    #1;
    check("coll_busy9", busy_vec[9], 1);
    check("coll_stall", hazard_stall, 1);
    step();

    // register zero
    apply_reset();
    issue_valid = 1'b1; issue_rd = 0;
    step();
    issue_valid = 1'b0;
    #1;
    check("z_busy", busy_vec, 0);
    req0_valid = 1'b1; req0_addr = 0; req0_data = 32'hFFFF;
    step();
    check("z_acc", acc, 0);
    req0_valid = 1'b0;
    #1;
    check("z_wr", rf_wr, 0);
    req0_valid = 1'b1; req0_addr = 2; req0_data = 32'h22;
    req1_valid = 1'b1; req1_addr = 6; req1_data = 32'h66;
    step();
    check("z_tie_grant", acc, 1);
    clear_inputs();
    step();

    // async reset mid-stream
    apply_reset();
    rs_addr = 7;
    issue_valid = 1'b1; issue_rd = 7;
    req0_valid = 1'b1; req0_addr = 3; req0_data = 32'h33;
    step();
    clear_inputs();
    rs_addr = 7;
    #2;
    check("ar_pre_wr", rf_wr, 1);
    check("ar_pre_busy", busy_vec, 32'h0000_0080);
    rst_n = 1'b0;
    #1;
    check("ar_wr", rf_wr, 0);
    check("ar_busy", busy_vec, 0);
    check("ar_stall", hazard_stall, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_addr = 1; req0_data = 32'h11;
    req1_valid = 1'b1; req1_addr = 2; req1_data = 32'h22;
    step();
    check("ar_first_tie", acc, 0);
    clear_inputs();

    // randomized traffic; requesters hold their request until accepted
    for (int c = 0; c < 400; c++) begin
      issue_valid = ($urandom_range(0, 2) == 0);
      issue_rd    = AW'($urandom_range(0, 15));
      rs_addr     = AW'($urandom_range(0, 15));
      rt_addr     = AW'($urandom_range(0, 15));
      if (!req0_valid || acc == 0) begin
        req0_valid = ($urandom_range(0, 9) < 6);
        req0_addr  = AW'($urandom_range(0, 15));
        req0_data  = $urandom;
      end
      if (!req1_valid || acc == 1) begin
        req1_valid = ($urandom_range(0, 9) < 6);
        req1_addr  = AW'($urandom_range(0, 15));
        req1_data  = $urandom;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rf_wb_arbiter.md
Name: rf_wb_arbiter

Overview:
- Shares the register file's single write port (A3/WD/RFWr) between two writeback requesters: req0 = ALU/EX result, req1 = load/MEM result.
- Uses round-robin arbitration with a registered output stage that drives the register file directly.
- Keeps a per-register pending-write scoreboard, set at instruction issue and cleared when the write commits.
- Raises a read-hazard stall to the decode stage.

Parameters:
- AW, 5, register address width.
- DW, 32, data width.
- NREG, 32, number of architectural registers (2**AW).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- issue_valid  in  1  instruction issued that will write issue_rd.
- issue_rd  in  AW  destination register of the issued instruction.
- rs_addr  in  AW  decode-stage source register 1.
- rt_addr  in  AW  decode-stage source register 2.
- hazard_stall  out  1  rs or rt has a pending write.
- req0_valid  in  1  EX writeback request.
- req0_addr  in  AW  EX destination.
- req0_data  in  DW  EX result.
- req0_ready  out  1  EX request accepted this cycle.
- req1_valid  in  1  MEM writeback request.
- req1_addr  in  AW  MEM destination.
- req1_data  in  DW  MEM result.
- req1_ready  out  1  MEM request accepted this cycle.
- rf_a3  out  AW  to register file A3.
- rf_wd  out  DW  to register file WD.
- rf_wr  out  1  to register file RFWr.
- busy_vec  out  NREG  scoreboard contents, for debug and verification.

Behaviour:
- Reset (async, rst_n=0): rf_wr=0, rf_a3=0, rf_wd=0, busy_vec=0, last_grant=1 (so req0 wins the first tie). hazard_stall=0 follows from busy_vec=0.
- Reset asserted mid-operation discards any pending grant and all busy bits immediately. No write is issued after reset releases until a new request is accepted.
- Arbitration (combinational, within one cycle):
  - Exactly one valid requester: it is granted.
  - Both valid: grant the requester other than last_grant.
  - reqN_ready = grant to N. At most one ready is high per cycle.
  - Throughput is one acceptance per cycle; the output stage is never back-pressured.
- Handshake:
  - A request is consumed at the posedge where valid & ready.
  - Requesters must hold valid, addr and data stable until accepted.
  - A request that is not granted stays pending; no data is lost.
- Output stage, at the acceptance edge N:
  - rf_a3 and rf_wd load the granted addr and data.
  - rf_wr = 1 if the granted addr != 0, else 0.
  - last_grant updates to the granted index.
  - With no acceptance at edge N, rf_wr is 0 after that edge; rf_a3 and rf_wd hold their values.
- Write latency: the register file commits at edge N+1, one cycle after acceptance.
- Scoreboard:
  - busy[r] is set at the posedge where issue_valid=1 and issue_rd=r, r!=0.
  - busy[r] is cleared at the posedge where rf_wr=1 and rf_a3=r (the commit edge).
  - Set and clear of the same r at the same edge: set wins (a new producer is outstanding).
  - busy[0] is always 0. issue_rd=0 is ignored.
- hazard_stall (combinational): (rs_addr!=0 & busy[rs_addr]) | (rt_addr!=0 & busy[rt_addr]).
  - No bypass: stall stays high through the commit cycle and drops the cycle after the commit edge.
- Requests to addr 0 are accepted and consume arbitration: last_grant updates, rf_wr stays 0.
- Writeback requests to a non-busy register are legal. They write normally and leave busy unchanged.

Test Plan:
- Reset, then req0 only: req0_valid=1, addr=5, data=0x1234 -> req0_ready=1 that cycle; next cycle rf_wr=1, rf_a3=5, rf_wd=0x00001234; following cycle rf_wr=0.
- Tie and round-robin: both valid every cycle (req0 addr 3/data 0xA, req1 addr 4/data 0xB) for 4 cycles -> grants alternate 0,1,0,1; rf_a3 sequence 3,4,3,4; never both ready.
- Scoreboard and stall:
  - issue_rd=7, then rs_addr=7 -> hazard_stall=1 from the cycle after issue.
  - req1 writes 7 -> stall stays 1 through the rf_wr cycle and drops to 0 the cycle after; busy_vec[7]=0.
- Set/clear collision: busy[9]=1 and a write to 9 committing at the same edge as issue_rd=9 -> busy_vec[9] remains 1; hazard_stall stays 1 for rs_addr=9.
- Register zero:
  - issue_rd=0 -> busy_vec=0.
  - req0 addr=0, data=0xFFFF -> req0_ready=1, rf_wr stays 0, last_grant=0, so a following tie grants req1.
- Async reset mid-stream: rst_n low between edges while rf_wr=1 and busy_vec=0x00000080 -> rf_wr, busy_vec and hazard_stall go to 0 immediately, without waiting for a clock edge; after release, the first tie grants req0.
